// File: rtl/am_key_receiver.sv
// Recovers a KEY_W-bit key, LSB first, from an on/off-keyed carrier: one bit per 8-slot symbol.
// Each symbol is a sync beep in slot 0, a data beep in slot 2 when the bit is 1, and silence elsewhere.
`timescale 1ns/1ps
module am_key_receiver #(
   parameter int SLOT_LOG2 = 23,
   parameter int HOLD_LOG2 = 17,
   parameter int KEY_W     = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_in,
   input  logic             arm,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             locked,
   output logic [7:0]       bit_cnt,
   output logic             frame_err
);
   // The symbol timer must count past 8 slots, up to the 8.5-slot timeout.
   localparam int SW = SLOT_LOG2 + 4;
   localparam int QW = SLOT_LOG2 + 2;
   localparam int unsigned HALF = 2 ** (SLOT_LOG2 - 1);

   localparam logic [SW-1:0]        SYNC_MIN  = SW'(HALF);
   localparam logic [SW-1:0]        SYNC_MAX  = SW'(3 * HALF);
   localparam logic [SW-1:0]        SAMPLE_AT = SW'(5 * HALF);
   localparam logic [SW-1:0]        NEXT_MIN  = SW'(15 * HALF);
   localparam logic [SW-1:0]        NEXT_MAX  = SW'(17 * HALF);
   localparam logic [QW-1:0]        QUIET_MAX = QW'(6 * HALF);
   localparam logic [HOLD_LOG2:0]   HOLD_INIT = {1'b1, {HOLD_LOG2{1'b0}}};
   localparam logic [7:0]           KEY_CNT   = 8'(KEY_W);

   typedef enum logic [1:0] {HUNT, SYNC, WAIT_DATA, WAIT_NEXT} state_t;

   state_t             state, state_nxt;
   logic [1:0]         sync_q;
   logic [HOLD_LOG2:0] hold_cnt;
   logic [QW-1:0]      quiet_cnt;
   logic [SW-1:0]      sym_cnt;
   logic [KEY_W-1:0]   shreg, shreg_nxt, key_nxt, shifted;
   logic [7:0]         bit_cnt_nxt, bit_inc;
   logic               rx_s, env, env_d, env_rise, env_fall, quiet_ok;
   logic               sym_clr, locked_nxt, kv_nxt, ferr_nxt;

   // A carrier gap exactly as long as the hold window would otherwise drop env for
   // the one cycle in which the next high arrives, so the synced input also holds env.
   assign rx_s     = sync_q[1];
   assign env      = rx_s | (hold_cnt != '0);
   assign env_rise = env & ~env_d;
   assign env_fall = ~env & env_d;
   assign quiet_ok = (quiet_cnt == QUIET_MAX);
   assign shifted  = {env, shreg[KEY_W-1:1]};
   assign bit_inc  = bit_cnt + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         hold_cnt  <= '0;
         env_d     <= 1'b0;
         quiet_cnt <= '0;
         sym_cnt   <= '0;
      end else begin
         sync_q <= {sync_q[0], rx_in};
         env_d  <= env;
         if (rx_s)
            hold_cnt <= HOLD_INIT;
         else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - (HOLD_LOG2+1)'(1);
         if (env)
            quiet_cnt <= '0;
         else if (!quiet_ok)
            quiet_cnt <= quiet_cnt + QW'(1);
         sym_cnt <= sym_clr ? '0 : sym_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HUNT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      sym_clr     = 1'b0;
      locked_nxt  = locked;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      key_nxt     = key_out;
      kv_nxt      = 1'b0;
      ferr_nxt    = 1'b0;
      if (arm) begin
         state_nxt   = HUNT;
         locked_nxt  = 1'b0;
         bit_cnt_nxt = '0;
         shreg_nxt   = '0;
      end else begin
         case (state)
            HUNT: begin
               // Data beeps follow a single quiet slot, so only a long silence marks a sync.
               if (env_rise && quiet_ok) begin
                  state_nxt = SYNC;
                  sym_clr   = 1'b1;
               end
            end
            SYNC: begin
               if (env_fall && sym_cnt >= SYNC_MIN && sym_cnt <= SYNC_MAX) begin
                  locked_nxt = 1'b1;
                  state_nxt  = WAIT_DATA;
               end else if (env_fall || (env && sym_cnt >= SYNC_MAX)) begin
                  state_nxt = HUNT;
                  if (locked) begin
                     ferr_nxt    = 1'b1;
                     bit_cnt_nxt = '0;
                     locked_nxt  = 1'b0;
                  end
               end
            end
            WAIT_DATA: begin
               if (sym_cnt == SAMPLE_AT) begin
                  shreg_nxt = shifted;
                  state_nxt = WAIT_NEXT;
                  if (bit_inc == KEY_CNT) begin
                     key_nxt     = shifted;
                     kv_nxt      = 1'b1;
                     bit_cnt_nxt = '0;
                  end else begin
                     bit_cnt_nxt = bit_inc;
                  end
               end
            end
            WAIT_NEXT: begin
               if (env_rise && sym_cnt >= NEXT_MIN && sym_cnt <= NEXT_MAX) begin
                  sym_clr   = 1'b1;
                  state_nxt = SYNC;
               end else if (env_rise || sym_cnt >= NEXT_MAX) begin
                  state_nxt   = HUNT;
                  ferr_nxt    = 1'b1;
                  locked_nxt  = 1'b0;
                  bit_cnt_nxt = '0;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
         locked    <= 1'b0;
         bit_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         shreg     <= shreg_nxt;
         key_out   <= key_nxt;
         key_valid <= kv_nxt;
         locked    <= locked_nxt;
         bit_cnt   <= bit_cnt_nxt;
         frame_err <= ferr_nxt;
      end
   end
endmodule

// File: tb/tb_am_key_receiver.sv
// Bench for am_key_receiver: drives keyed beeps symbol by symbol and checks recovered keys,
// lock state, bit count and error pulses against the bit sequence it transmitted.
`timescale 1ns/1ps
module tb_am_key_receiver;
   localparam int SLOT_LOG2 = 8;
   localparam int HOLD_LOG2 = 4;
   localparam int KEY_W     = 128;
   localparam int SLOT      = 1 << SLOT_LOG2;
   localparam int SYMBOL    = 8 * SLOT;
   localparam logic [KEY_W-1:0] CLEAN_KEY = 128'h0123456789ABCDEF_FEDCBA9876543210;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rx_in = 1'b0;
   logic             arm = 1'b0;
   logic [KEY_W-1:0] key_out;
   logic             key_valid, locked, frame_err;
   logic [7:0]       bit_cnt;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_sync_cyc = 0;
   int kv_cycs[$];
   logic [KEY_W-1:0] kv_keys[$];
   int fe_cycs[$];

   am_key_receiver #(.SLOT_LOG2(SLOT_LOG2), .HOLD_LOG2(HOLD_LOG2), .KEY_W(KEY_W)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .arm(arm),
      .key_out(key_out), .key_valid(key_valid), .locked(locked),
      .bit_cnt(bit_cnt), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         kv_cycs.push_back(cyc);
         kv_keys.push_back(key_out);
      end
      if (frame_err === 1'b1) fe_cycs.push_back(cyc);
   end

   // Beep: 16 cycles of carrier on, 16 off, repeated; line low afterwards.
   task automatic beep(input int n);
      for (int i = 0; i < n; i++) begin
         rx_in = ((i / 16) % 2 == 0) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      rx_in = 1'b0;
   endtask

   task automatic quiet(input int n);
      rx_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_slots(input logic b, input int first, input int last);
      for (int s = first; s <= last; s++) begin
         if (s == 0) begin
            last_sync_cyc = cyc;
            beep(SLOT);
         end else if (s == 2 && b) beep(SLOT);
         else quiet(SLOT);
      end
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (key_out !== '0) begin miscompares++; $display("FAIL reset_key_out got %h want 0", key_out); end
      vectors++;
      if (bit_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
      vectors++;
      if ({key_valid, locked, frame_err} !== 3'b000) begin
         miscompares++; $display("FAIL reset_flags got kv=%b lk=%b fe=%b want 000", key_valid, locked, frame_err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int kv0, fe0;
      logic b;
      logic [KEY_W-1:0] exp_frame [2];
      kv0 = kv_cycs.size();
      fe0 = fe_cycs.size();
      quiet(1024);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < KEY_W; i++) begin
            b = (f == 0) ? 1'b1 : 1'b0;
            exp_frame[f][i] = b;
            tx_slots(b, 0, 7);
            vectors++;
            if (bit_cnt !== 8'((i + 1) % KEY_W)) begin
               miscompares++; $display("FAIL b2b_bit_cnt f%0d s%0d got %0d want %0d", f, i, bit_cnt, (i + 1) % KEY_W);
            end
            vectors++;
            if (locked !== 1'b1) begin miscompares++; $display("FAIL b2b_locked f%0d s%0d got %b want 1", f, i, locked); end
         end
      end
      vectors++;
      if (kv_cycs.size() != kv0 + 2) begin
         miscompares++; $display("FAIL b2b_kv_count got %0d want 2", kv_cycs.size() - kv0);
      end else begin
         vectors++;
         if (kv_cycs[kv0+1] - kv_cycs[kv0] != SYMBOL * KEY_W) begin
            miscompares++; $display("FAIL b2b_kv_spacing got %0d want %0d", kv_cycs[kv0+1] - kv_cycs[kv0], SYMBOL * KEY_W);
         end
         vectors++;
         if (kv_keys[kv0] !== exp_frame[0]) begin miscompares++; $display("FAIL b2b_key0 got %h want %h", kv_keys[kv0], exp_frame[0]); end
         vectors++;
         if (kv_keys[kv0+1] !== exp_frame[1]) begin miscompares++; $display("FAIL b2b_key1 got %h want %h", kv_keys[kv0+1], exp_frame[1]); end
      end
      vectors++;
      if (fe_cycs.size() != fe0) begin miscompares++; $display("FAIL b2b_frame_err got %0d pulses want 0", fe_cycs.size() - fe0); end
   endtask

   task automatic test_clean_frame();
      int kv0, fe0;
      logic [KEY_W-1:0] k, exp_key;
      logic sent[$];
      k = CLEAN_KEY;
      pulse_arm();
      quiet(1024);
      kv0 = kv_cycs.size();
      fe0 = fe_cycs.size();
      for (int i = 0; i < KEY_W; i++) begin
         tx_slots(k[i], 0, 7);
         sent.push_back(k[i]);
         vectors++;
         if (locked !== 1'b1) begin miscompares++; $display("FAIL clean_locked s%0d got %b want 1", i, locked); end
      end
      for (int j = 0; j < KEY_W; j++) exp_key[j] = sent[j];
      vectors++;
      if (kv_cycs.size() != kv0 + 1) begin
         miscompares++; $display("FAIL clean_kv_count got %0d want 1", kv_cycs.size() - kv0);
      end else begin
         vectors++;
         if (kv_keys[kv0] !== exp_key) begin miscompares++; $display("FAIL clean_key_at_valid got %h want %h", kv_keys[kv0], exp_key); end
      end
      vectors++;
      if (key_out !== exp_key) begin miscompares++; $display("FAIL clean_key_out got %h want %h", key_out, exp_key); end
      vectors++;
      if (fe_cycs.size() != fe0) begin miscompares++; $display("FAIL clean_frame_err got %0d pulses want 0", fe_cycs.size() - fe0); end
   endtask

   task automatic test_sync_width();
      int fe0;
      pulse_arm();
      quiet(1000);
      fe0 = fe_cycs.size();
      beep(600);
      quiet(1000);
      vectors++;
      if (locked !== 1'b0) begin miscompares++; $display("FAIL wide_sync_locked got %b want 0", locked); end
      vectors++;
      if (fe_cycs.size() != fe0) begin miscompares++; $display("FAIL wide_sync_frame_err got %0d want 0", fe_cycs.size() - fe0); end
      tx_slots(1'($urandom_range(0, 1)), 0, 7);
      vectors++;
      if (locked !== 1'b1 || bit_cnt !== 8'd1) begin
         miscompares++; $display("FAIL relock_after_hunt got lk=%b cnt=%0d want lk=1 cnt=1", locked, bit_cnt);
      end
      for (int i = 1; i < 40; i++) tx_slots(1'($urandom_range(0, 1)), 0, 7);
      vectors++;
      if (bit_cnt !== 8'd40) begin miscompares++; $display("FAIL pre_err_bit_cnt got %0d want 40", bit_cnt); end
      fe0 = fe_cycs.size();
      beep(600);
      quiet(1500);
      vectors++;
      if (fe_cycs.size() != fe0 + 1) begin miscompares++; $display("FAIL locked_wide_sync_frame_err got %0d want 1", fe_cycs.size() - fe0); end
      vectors++;
      if (bit_cnt !== 8'd0 || locked !== 1'b0) begin
         miscompares++; $display("FAIL locked_wide_sync_state got cnt=%0d lk=%b want cnt=0 lk=0", bit_cnt, locked);
      end
   endtask

   task automatic test_dropout();
      int fe0, delta;
      pulse_arm();
      quiet(1024);
      for (int i = 0; i < 70; i++) tx_slots(1'($urandom_range(0, 1)), 0, 7);
      vectors++;
      if (bit_cnt !== 8'd70) begin miscompares++; $display("FAIL dropout_bit_cnt_before got %0d want 70", bit_cnt); end
      fe0 = fe_cycs.size();
      quiet(3000);
      vectors++;
      if (fe_cycs.size() != fe0 + 1) begin
         miscompares++; $display("FAIL dropout_frame_err_count got %0d want 1", fe_cycs.size() - fe0);
      end else begin
         // 8.5 slots after the sync rise, plus a few cycles of synchronizer and register latency.
         delta = fe_cycs[fe0] - last_sync_cyc;
         vectors++;
         if (delta < 2176 || delta > 2184) begin
            miscompares++; $display("FAIL dropout_frame_err_time got %0d want 2176..2184", delta);
         end
      end
      vectors++;
      if (locked !== 1'b0 || bit_cnt !== 8'd0) begin
         miscompares++; $display("FAIL dropout_state got lk=%b cnt=%0d want lk=0 cnt=0", locked, bit_cnt);
      end
      vectors++;
      if (key_out !== CLEAN_KEY) begin miscompares++; $display("FAIL dropout_key_hold got %h want %h", key_out, CLEAN_KEY); end
   endtask

   task automatic test_midstream_arm();
      int kv0, fe0, split;
      logic [KEY_W-1:0] k;
      k = {$urandom, $urandom, $urandom, $urandom};
      pulse_arm();
      quiet(1024);
      kv0 = kv_cycs.size();
      fe0 = fe_cycs.size();
      tx_slots(k[3], 4, 7);
      for (int n = 1; n <= 90; n++) begin
         tx_slots(k[(n + 3) % KEY_W], 0, 7);
         vectors++;
         if (bit_cnt !== 8'(n)) begin miscompares++; $display("FAIL midstream_bit_cnt s%0d got %0d want %0d", n, bit_cnt, n); end
      end
      tx_slots(1'b1, 0, 0);
      split = $urandom_range(20, 200);
      quiet(split);
      pulse_arm();
      vectors++;
      if (bit_cnt !== 8'd0 || locked !== 1'b0) begin
         miscompares++; $display("FAIL arm_clear got cnt=%0d lk=%b want cnt=0 lk=0", bit_cnt, locked);
      end
      quiet(SLOT - split - 1);
      tx_slots(1'b1, 2, 7);
      vectors++;
      if (locked !== 1'b0) begin miscompares++; $display("FAIL data_beep_lock got %b want 0", locked); end
      tx_slots(1'b1, 0, 7);
      tx_slots(1'b0, 0, 7);
      vectors++;
      if (locked !== 1'b1 || bit_cnt !== 8'd2) begin
         miscompares++; $display("FAIL relock_after_arm got lk=%b cnt=%0d want lk=1 cnt=2", locked, bit_cnt);
      end
      vectors++;
      if (kv_cycs.size() != kv0) begin miscompares++; $display("FAIL midstream_false_valid got %0d want 0", kv_cycs.size() - kv0); end
      vectors++;
      if (fe_cycs.size() != fe0) begin miscompares++; $display("FAIL arm_frame_err got %0d want 0", fe_cycs.size() - fe0); end
      vectors++;
      if (key_out !== CLEAN_KEY) begin miscompares++; $display("FAIL arm_key_hold got %h want %h", key_out, CLEAN_KEY); end
   endtask

   task automatic test_reset_midframe();
      int kv0, fe0;
      tx_slots(1'b1, 0, 1);
      kv0 = kv_cycs.size();
      fe0 = fe_cycs.size();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (key_out !== '0) begin miscompares++; $display("FAIL async_rst_key_out got %h want 0", key_out); end
      vectors++;
      if ({key_valid, locked, frame_err} !== 3'b000 || bit_cnt !== 8'd0) begin
         miscompares++; $display("FAIL async_rst_outputs got kv=%b lk=%b fe=%b cnt=%0d want all 0", key_valid, locked, frame_err, bit_cnt);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      quiet(3000);
      vectors++;
      if (kv_cycs.size() != kv0 || fe_cycs.size() != fe0) begin
         miscompares++; $display("FAIL post_rst_pulses got kv=%0d fe=%0d want 0 0", kv_cycs.size() - kv0, fe_cycs.size() - fe0);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_clean_frame();
      test_sync_width();
      test_dropout();
      test_midstream_arm();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
